// File: rtl/waterfall_pkg.sv
// Shared types and helpers for the waterfall scheduler: FSM state encoding,
// default geometry and the magnitude-to-pixel scaling function.
package waterfall_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SDFT,
    WAIT_VBLANK,
    COPY,
    ADVANCE
  } state_t;

  localparam int FREQ_BINS_DEF           = 320;
  localparam int V_VISIBLE_DEF           = 240;
  localparam int REFRESH_BRAM_CYCLES_DEF = 20;
  localparam int BIN_W_DEF               = 16;
  localparam int DATA_W_DEF              = 8;
  localparam int SHIFT_DEF               = 4;
  localparam int MISSED_W                = 8;

  localparam int BIN_AW_DEF = $clog2(FREQ_BINS_DEF);
  localparam int ROW_W_DEF  = $clog2(V_VISIBLE_DEF);
  localparam int ADDR_W_DEF = $clog2(FREQ_BINS_DEF * V_VISIBLE_DEF);

  // Shift the magnitude down, then clamp to the largest data_w-bit pixel.
  function automatic logic [31:0] scale_pixel(input logic [31:0] mag,
                                              input int          shift,
                                              input int          data_w);
    logic [31:0] v;
    logic [31:0] max_v;
    v     = mag >> shift;
    max_v = (32'd1 << data_w) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/waterfall_scheduler_if.sv
// Scheduler-facing bundle: ADC strobe, SDFT control/bin read, BRAM write port,
// display timing and status. master = scheduler, slave = surrounding datapath.
interface waterfall_scheduler_if #(
  parameter int BIN_AW = 9,
  parameter int BIN_W  = 16,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8
);
  logic              adc_valid;
  logic              sdft_start;
  logic              sdft_ready;
  logic [BIN_AW-1:0] bin_rd_addr;
  logic [BIN_W-1:0]  bin_rd_data;
  logic              vblank;
  logic              bram_wr_en;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic [ROW_W-1:0]  row_ptr;
  logic [7:0]        missed;

  modport master (
    input  adc_valid, sdft_ready, bin_rd_data, vblank,
    output sdft_start, bin_rd_addr, bram_wr_en, bram_wr_addr, bram_wr_data,
           row_ptr, missed
  );

  modport slave (
    output adc_valid, sdft_ready, bin_rd_data, vblank,
    input  sdft_start, bin_rd_addr, bram_wr_en, bram_wr_addr, bram_wr_data,
           row_ptr, missed
  );
endinterface

// File: rtl/waterfall_row_copier.sv
// Streams every SDFT bin into one BRAM row: address counter, one-cycle read
// pipeline, scale/saturate, write strobe. start_i launches, done_o marks the last write.
module waterfall_row_copier
  import waterfall_pkg::*;
#(
  parameter int FREQ_BINS = FREQ_BINS_DEF,
  parameter int BIN_AW    = BIN_AW_DEF,
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SHIFT     = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] row_base_i,
  output logic [BIN_AW-1:0] bin_rd_addr_o,
  input  logic [BIN_W-1:0]  bin_rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              done_o
);

  localparam logic [BIN_AW-1:0] BIN_LAST = BIN_AW'(FREQ_BINS - 1);

  logic              busy_q, busy_d;
  logic [BIN_AW-1:0] cnt_q, cnt_d;
  logic              pend_q;
  logic [BIN_AW-1:0] pend_bin_q;
  logic [DATA_W-1:0] pixel;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + BIN_AW'(1);
      if (cnt_q == BIN_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_bin_q <= '0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      pend_q     <= busy_q;
      pend_bin_q <= cnt_q;
    end
  end

  // Read data returns one cycle after its address, so the write trails by one.
  assign pixel         = DATA_W'(scale_pixel(32'(bin_rd_data_i), SHIFT, DATA_W));
  assign bin_rd_addr_o = cnt_q;
  assign wr_en_o       = pend_q;
  assign wr_addr_o     = pend_q ? (row_base_i + ADDR_W'(pend_bin_q)) : '0;
  assign wr_data_o     = pend_q ? pixel : '0;
  assign done_o        = pend_q && (pend_bin_q == BIN_LAST);

endmodule

// File: rtl/waterfall_scheduler.sv
// Spectrum datapath sequencer: one SDFT update per ADC sample and, every
// REFRESH_BRAM_CYCLES samples, a vblank-gated copy of all bins into the next waterfall row.
module waterfall_scheduler
  import waterfall_pkg::*;
#(
  parameter int FREQ_BINS           = FREQ_BINS_DEF,
  parameter int V_VISIBLE           = V_VISIBLE_DEF,
  parameter int REFRESH_BRAM_CYCLES = REFRESH_BRAM_CYCLES_DEF,
  parameter int BIN_W               = BIN_W_DEF,
  parameter int DATA_W              = DATA_W_DEF,
  parameter int SHIFT               = SHIFT_DEF
) (
  input  logic                  clock_in,
  input  logic                  reset,
  waterfall_scheduler_if.master bus
);

  localparam int BIN_AW = $clog2(FREQ_BINS);
  localparam int ROW_W  = $clog2(V_VISIBLE);
  localparam int ADDR_W = $clog2(FREQ_BINS * V_VISIBLE);
  localparam int CNT_W  = $clog2(REFRESH_BRAM_CYCLES + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REFRESH_BRAM_CYCLES);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic                 pending_q, pending_d;
  logic [MISSED_W-1:0]  missed_q, missed_d;
  logic [ROW_W-1:0]     row_ptr_q, row_ptr_d;
  logic [ROW_W-1:0]     next_row;
  logic [ADDR_W-1:0]    row_base;
  logic                 sample_req;
  logic                 take_sample;
  logic                 copy_start;
  logic                 copy_done;

  assign next_row    = (row_ptr_q == ROW_LAST) ? '0 : row_ptr_q + ROW_W'(1);
  assign row_base    = ADDR_W'(next_row) * ADDR_W'(FREQ_BINS);
  assign sample_req  = bus.adc_valid || pending_q;
  assign take_sample = (state_q == IDLE) && sample_req && bus.sdft_ready;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    pending_d    = pending_q;
    missed_d     = missed_q;
    row_ptr_d    = row_ptr_q;
    copy_start   = 1'b0;

    // One-deep sample buffer; a strobe arriving as the buffer drains refills it.
    if (take_sample) begin
      pending_d = pending_q && bus.adc_valid;
    end else if (bus.adc_valid) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (missed_q != '1) begin
        missed_d = missed_q + MISSED_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (take_sample) state_d = START;
      end
      START: begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
        state_d      = WAIT_SDFT;
      end
      WAIT_SDFT: begin
        if (bus.sdft_ready) begin
          if (sample_cnt_q >= CNT_FULL) begin
            sample_cnt_d = '0;
            state_d      = WAIT_VBLANK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_VBLANK: begin
        if (bus.vblank) begin
          copy_start = 1'b1;
          state_d    = COPY;
        end
      end
      COPY: begin
        if (copy_done) state_d = ADVANCE;
      end
      ADVANCE: begin
        row_ptr_d = next_row;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      pending_q    <= 1'b0;
      missed_q     <= '0;
      row_ptr_q    <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      pending_q    <= pending_d;
      missed_q     <= missed_d;
      row_ptr_q    <= row_ptr_d;
    end
  end

  waterfall_row_copier #(
    .FREQ_BINS (FREQ_BINS),
    .BIN_AW    (BIN_AW),
    .BIN_W     (BIN_W),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SHIFT     (SHIFT)
  ) u_copier (
    .clk           (clock_in),
    .rst_n         (reset),
    .start_i       (copy_start),
    .row_base_i    (row_base),
    .bin_rd_addr_o (bus.bin_rd_addr),
    .bin_rd_data_i (bus.bin_rd_data),
    .wr_en_o       (bus.bram_wr_en),
    .wr_addr_o     (bus.bram_wr_addr),
    .wr_data_o     (bus.bram_wr_data),
    .done_o        (copy_done)
  );

  assign bus.sdft_start = (state_q == START);
  assign bus.row_ptr    = row_ptr_q;
  assign bus.missed     = missed_q;

endmodule

// File: tb/tb_waterfall_scheduler.sv
// Scoreboard bench for waterfall_scheduler: expected BRAM writes are queued as
// stimulus is issued; a negedge monitor pops and compares each write.
module tb_waterfall_scheduler;

  localparam int FB = 64;
  localparam int VV = 10;
  localparam int RC = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  waterfall_scheduler_if #(
    .BIN_AW (6),
    .BIN_W  (16),
    .ADDR_W (10),
    .DATA_W (8),
    .ROW_W  (4)
  ) bus ();

  waterfall_scheduler #(
    .FREQ_BINS           (FB),
    .V_VISIBLE           (VV),
    .REFRESH_BRAM_CYCLES (RC),
    .BIN_W               (16),
    .DATA_W              (8),
    .SHIFT               (4)
  ) dut (
    .clock_in (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic [3:0] rp;
  } wr_exp_t;

  wr_exp_t     exp_q[$];
  wr_exp_t     mon_e;
  logic [15:0] mag [FB];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  int          n_pushed = 0;
  int          n_starts = 0;
  int          sdft_busy;
  int          tb_cnt;
  int          nr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [7:0] px(input logic [15:0] m);
    logic [15:0] v;
    v = m >> 4;
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // SDFT model: busy for 5 cycles after each start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sdft_ready <= 1'b1;
      sdft_busy      <= 0;
    end else if (bus.sdft_start) begin
      bus.sdft_ready <= 1'b0;
      sdft_busy      <= 5;
    end else if (sdft_busy > 0) begin
      sdft_busy <= sdft_busy - 1;
      if (sdft_busy == 1) bus.sdft_ready <= 1'b1;
    end
  end

  // Bin memory model: registered read.
  always @(posedge clk) bus.bin_rd_data <= mag[bus.bin_rd_addr];

  // Monitor.
  always @(negedge clk) begin
    if (bus.sdft_start) n_starts++;
    if (bus.bram_wr_en) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.bram_wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.bram_wr_data), 32'(mon_e.data));
        check("row_ptr_during_copy", 32'(bus.row_ptr), 32'(mon_e.rp));
      end
    end
  end

  task automatic fill_mag(input int r);
    for (int k = 0; k < FB; k++) mag[k] = 16'((k + r) * 64);
  endtask

  task automatic push_row(input int row, input int nbins, input int rp);
    wr_exp_t e;
    for (int k = 0; k < nbins; k++) begin
      e.addr = 10'(row * FB + k);
      e.data = px(mag[k]);
      e.rp   = 4'(rp);
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic send_pulse();
    @(negedge clk);
    bus.adc_valid = 1'b1;
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  task automatic send_sample();
    send_pulse();
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_row(input int r, input string name);
    for (int i = 0; i < 300 && bus.row_ptr !== 4'(r); i++) @(negedge clk);
    check(name, 32'(bus.row_ptr), 32'(r));
  endtask

  initial begin
    bus.adc_valid = 1'b0;
    bus.vblank    = 1'b0;
    fill_mag(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_sdft_start", 32'(bus.sdft_start), 32'd0);
    check("rst_wr_en", 32'(bus.bram_wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.bram_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.bram_wr_data), 32'd0);
    check("rst_bin_addr", 32'(bus.bin_rd_addr), 32'd0);
    check("rst_row_ptr", 32'(bus.row_ptr), 32'd0);
    check("rst_missed", 32'(bus.missed), 32'd0);

    // 19 samples: SDFT updates only.
    repeat (19) send_sample();
    check("t1_starts", 32'(n_starts), 32'd19);
    check("t1_writes", 32'(n_writes), 32'd0);

    // 20th sample with vblank: row 1 copied, saturation vectors in bins 0..2.
    fill_mag(1);
    mag[0] = 16'h0FF0;
    mag[1] = 16'h1000;
    mag[2] = 16'h0050;
    push_row(1, FB, 0);
    exp_q[0].data = 8'hFF;
    exp_q[1].data = 8'hFF;
    exp_q[2].data = 8'h05;
    bus.vblank = 1'b1;
    send_sample();
    wait_row(1, "t2_row_ptr");
    check("t2_starts", 32'(n_starts), 32'd20);
    check("t2_writes", 32'(n_writes), 32'd64);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Copy held off by vblank; one sample buffered, one dropped.
    bus.vblank = 1'b0;
    fill_mag(2);
    repeat (20) send_sample();
    check("t4_no_write_wo_vblank", 32'(n_writes), 32'd64);
    send_sample();
    send_sample();
    check("t4_missed", 32'(bus.missed), 32'd1);
    check("t4_starts_held", 32'(n_starts), 32'd40);
    push_row(2, FB, 1);
    bus.vblank = 1'b1;
    wait_row(2, "t4_row_ptr");
    for (int i = 0; i < 50 && n_starts < 41; i++) @(negedge clk);
    check("t4_pending_start", 32'(n_starts), 32'd41);
    check("t4_missed_kept", 32'(bus.missed), 32'd1);
    repeat (10) @(negedge clk);
    tb_cnt = 1;

    // Eight more rows: 3..9 then wrap to 0 (addresses 0..63).
    for (int c = 0; c < 8; c++) begin
      nr = (c + 3) % VV;
      fill_mag(nr);
      for (int s = tb_cnt; s < RC; s++) begin
        if (s == RC - 1) push_row(nr, FB, (nr + VV - 1) % VV);
        send_sample();
      end
      tb_cnt = 0;
      wait_row(nr, "t5_row_ptr");
    end
    check("t5_writes", 32'(n_writes), 32'd640);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while copying bin 30 of row 1.
    fill_mag(5);
    repeat (19) send_sample();
    push_row(1, 30, 0);
    send_pulse();
    for (int i = 0; i < 200 && bus.bin_rd_addr !== 6'd30; i++) @(negedge clk);
    check("t6_reached_bin30", 32'(bus.bin_rd_addr), 32'd30);
    #1 rst_n = 1'b0;
    #1;
    check("t6_wr_en_low", 32'(bus.bram_wr_en), 32'd0);
    check("t6_row_ptr", 32'(bus.row_ptr), 32'd0);
    check("t6_missed_cleared", 32'(bus.missed), 32'd0);
    check("t6_bin_addr", 32'(bus.bin_rd_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_writes", 32'(n_writes), 32'd670);
    check("t6_pushed_vs_writes", 32'(n_writes), 32'(n_pushed));
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_row_ptr_after", 32'(bus.row_ptr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
